vector_issue_scheduler: RTL and testbench

//   Sequences vector instructions into VECTOR_FUNCTION_UNIT (VFU). Buffers decoded vector ops in a

---
 rtl/vector_issue_scheduler.sv | 178 +++++++++++++++++
 tb/tb_vector_issue_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_issue_scheduler.sv
// Vector issue scheduler: queues decoded vector ops and issues them one at a time to the VFU,
// then holds the captured result for writeback over a valid/ready handshake.
module vector_issue_scheduler #(
   parameter int unsigned DATA_LEN    = 32,
   parameter int unsigned VECTOR_SIZE = 8,
   parameter int unsigned TAG_WIDTH   = 8,
   parameter int unsigned QUEUE_DEPTH = 4,
   parameter int unsigned PTR_WIDTH   = 2,
   parameter int unsigned MAX_CYCLES  = 64
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            rdy_in,
   input  logic                            req_valid,
   output logic                            req_ready,
   input  logic [TAG_WIDTH-1:0]            req_tag,
   input  logic [DATA_LEN-1:0]             req_length,
   output logic                            vfu_execute,
   output logic [DATA_LEN-1:0]             vfu_length,
   output logic [TAG_WIDTH-1:0]            vfu_tag,
   input  logic [1:0]                      vfu_status,
   input  logic [VECTOR_SIZE*DATA_LEN-1:0] vfu_result,
   input  logic                            vfu_is_mask,
   output logic                            wb_valid,
   input  logic                            wb_ready,
   output logic [TAG_WIDTH-1:0]            wb_tag,
   output logic [VECTOR_SIZE*DATA_LEN-1:0] wb_result,
   output logic                            wb_is_mask,
   output logic                            wb_skip,
   output logic                            wb_error,
   output logic                            busy
);

   localparam int unsigned RES_W = VECTOR_SIZE * DATA_LEN;
   localparam int unsigned CNT_W = PTR_WIDTH + 1;
   localparam int unsigned WD_W  = $clog2(MAX_CYCLES) + 1;
   localparam logic [1:0] ST_NOP      = 2'b00;
   localparam logic [1:0] ST_FINISHED = 2'b10;

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, WB} state_t;

   state_t               state, state_nx;
   logic [TAG_WIDTH-1:0] q_tag [QUEUE_DEPTH];
   logic [DATA_LEN-1:0]  q_len [QUEUE_DEPTH];
   logic [PTR_WIDTH-1:0] head, tail;
   logic [CNT_W-1:0]     count;
   logic [WD_W-1:0]      wd, wd_nx;
   logic                 push, pop;
   logic                 in_flight;

   logic                 wb_valid_nx, wb_is_mask_nx, wb_skip_nx, wb_error_nx;
   logic [TAG_WIDTH-1:0] wb_tag_nx;
   logic [RES_W-1:0]     wb_result_nx;

   assign req_ready   = count < CNT_W'(QUEUE_DEPTH);
   assign push        = req_valid & req_ready & rdy_in;
   assign in_flight   = (state == ISSUE) || (state == BUSY);
   assign vfu_execute = (state == ISSUE) & rdy_in;
   assign vfu_length  = in_flight ? q_len[head] : '0;
   assign vfu_tag     = in_flight ? q_tag[head] : '0;
   assign busy        = (state != IDLE) || (count != '0);

   // Queue storage carries no reset; validity is tracked by head/tail/count.
   always_ff @(posedge clk) begin
      if (push) begin
         q_tag[tail] <= req_tag;
         q_len[tail] <= req_length;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PTR_WIDTH'(1);
         if (pop)  head <= head + PTR_WIDTH'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         wd         <= '0;
         wb_valid   <= 1'b0;
         wb_tag     <= '0;
         wb_result  <= '0;
         wb_is_mask <= 1'b0;
         wb_skip    <= 1'b0;
         wb_error   <= 1'b0;
      end else begin
         state      <= state_nx;
         wd         <= wd_nx;
         wb_valid   <= wb_valid_nx;
         wb_tag     <= wb_tag_nx;
         wb_result  <= wb_result_nx;
         wb_is_mask <= wb_is_mask_nx;
         wb_skip    <= wb_skip_nx;
         wb_error   <= wb_error_nx;
      end
   end

   // Next-state and writeback capture; nothing advances while rdy_in is low.
   always_comb begin
      state_nx      = state;
      pop           = 1'b0;
      wd_nx         = wd;
      wb_valid_nx   = wb_valid;
      wb_tag_nx     = wb_tag;
      wb_result_nx  = wb_result;
      wb_is_mask_nx = wb_is_mask;
      wb_skip_nx    = wb_skip;
      wb_error_nx   = wb_error;
      if (rdy_in) begin
         case (state)
            IDLE: begin
               if ((count != '0) && (vfu_status == ST_NOP)) begin
                  if (q_len[head] == '0) begin
                     state_nx      = WB;
                     pop           = 1'b1;
                     wb_valid_nx   = 1'b1;
                     wb_tag_nx     = q_tag[head];
                     wb_result_nx  = '0;
                     wb_is_mask_nx = 1'b0;
                     wb_skip_nx    = 1'b1;
                     wb_error_nx   = 1'b0;
                  end else begin
                     state_nx = ISSUE;
                  end
               end
            end
            ISSUE: begin
               wd_nx    = '0;
               state_nx = BUSY;
            end
            BUSY: begin
               if (vfu_status == ST_FINISHED) begin
                  state_nx      = WB;
                  pop           = 1'b1;
                  wb_valid_nx   = 1'b1;
                  wb_tag_nx     = q_tag[head];
                  wb_result_nx  = vfu_result;
                  wb_is_mask_nx = vfu_is_mask;
                  wb_skip_nx    = 1'b0;
                  wb_error_nx   = 1'b0;
               end else if (wd == WD_W'(MAX_CYCLES - 1)) begin
                  state_nx      = WB;
                  pop           = 1'b1;
                  wb_valid_nx   = 1'b1;
                  wb_tag_nx     = q_tag[head];
                  wb_result_nx  = '0;
                  wb_is_mask_nx = 1'b0;
                  wb_skip_nx    = 1'b0;
                  wb_error_nx   = 1'b1;
               end else begin
                  wd_nx = wd + WD_W'(1);
               end
            end
            WB: begin
               if (wb_ready) begin
                  state_nx    = IDLE;
                  wb_valid_nx = 1'b0;
                  wb_skip_nx  = 1'b0;
                  wb_error_nx = 1'b0;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vector_issue_scheduler.sv
// Randomized bench for vector_issue_scheduler: a tag-driven VFU model plus an in-order
// scoreboard of accepted ops predicting issue order, writeback contents and latencies.
module tb_vector_issue_scheduler;

   localparam int unsigned RES_W   = 256;
   localparam logic [7:0]  TAG_STK = 8'hEE;

   logic             clk = 1'b0;
   logic             rst, rdy_in, req_valid, req_ready;
   logic [7:0]       req_tag;
   logic [31:0]      req_length;
   logic             vfu_execute;
   logic [31:0]      vfu_length;
   logic [7:0]       vfu_tag;
   logic [1:0]       vfu_status;
   logic [RES_W-1:0] vfu_result;
   logic             vfu_is_mask;
   logic             wb_valid, wb_ready, wb_is_mask, wb_skip, wb_error, busy;
   logic [7:0]       wb_tag;
   logic [RES_W-1:0] wb_result;

   vector_issue_scheduler dut (
      .clk(clk), .rst(rst), .rdy_in(rdy_in),
      .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag), .req_length(req_length),
      .vfu_execute(vfu_execute), .vfu_length(vfu_length), .vfu_tag(vfu_tag),
      .vfu_status(vfu_status), .vfu_result(vfu_result), .vfu_is_mask(vfu_is_mask),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_result(wb_result),
      .wb_is_mask(wb_is_mask), .wb_skip(wb_skip), .wb_error(wb_error), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  tag;
      logic [31:0] len;
   } op_t;

   op_t exp_q[$];
   op_t iss_q[$];
   int  n_cmp = 0;
   int  n_err = 0;
   int  cyc = 0;
   logic rand_wb = 1'b0;

   task automatic check(input string tag, input logic [RES_W-1:0] got, input logic [RES_W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [RES_W-1:0] res_of(input logic [7:0] t);
      logic [31:0] w;
      w = {t, ~t, t ^ 8'h5A, t + 8'd1};
      return {8{w}};
   endfunction

   function automatic int delay_of(input logic [7:0] t);
      return int'(t % 8'd5) + 1;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // VFU model: WORKING for delay_of(tag) cycles, one FINISHED cycle, then NOP.
   // The stuck tag never finishes and only drops back once the scheduler aborts it.
   logic [7:0] cur_tag;
   logic       stuck;
   int         rem;
   always @(negedge clk or posedge rst) begin
      if (rst) begin
         vfu_status  <= 2'b00;
         vfu_result  <= '0;
         vfu_is_mask <= 1'b0;
         rem         <= 0;
         stuck       <= 1'b0;
         cur_tag     <= '0;
      end else begin
         vfu_result  <= {8{$urandom}};
         vfu_is_mask <= ~cur_tag[0];
         case (vfu_status)
            2'b00: if (vfu_execute) begin
               cur_tag    <= vfu_tag;
               stuck      <= (vfu_tag == TAG_STK);
               rem        <= delay_of(vfu_tag);
               vfu_status <= 2'b01;
            end
            2'b01: begin
               if (stuck) begin
                  if (wb_valid) vfu_status <= 2'b00;
               end else if (rem == 1) begin
                  vfu_status  <= 2'b10;
                  vfu_result  <= res_of(cur_tag);
                  vfu_is_mask <= cur_tag[0];
               end else begin
                  rem <= rem - 1;
               end
            end
            default: vfu_status <= 2'b00;
         endcase
      end
   end

   // Scoreboard monitor, sampled on the falling edge.
   logic             wb_valid_d = 1'b0;
   logic             inflight = 1'b0;
   int               exec_cyc, exec_lat;
   logic             hold = 1'b0;
   logic [7:0]       h_tag;
   logic [RES_W-1:0] h_res;
   logic [2:0]       h_flags;
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         iss_q.delete();
         inflight   = 1'b0;
         hold       = 1'b0;
         wb_valid_d = 1'b0;
      end else begin
         op_t o;
         logic skip, err;
         check("busy", busy, exp_q.size() != 0);
         check("req_ready", req_ready, (exp_q.size() - (wb_valid ? 1 : 0)) < 4);
         if (req_valid && req_ready && rdy_in) begin
            o.tag = req_tag;
            o.len = req_length;
            exp_q.push_back(o);
            if (req_length != 0) iss_q.push_back(o);
         end
         if (vfu_execute) begin
            if (iss_q.size() == 0) check("exec_unexpected", 1, 0);
            else begin
               o = iss_q.pop_front();
               check("exec_tag", vfu_tag, o.tag);
               check("exec_len", vfu_length, o.len);
               exec_cyc = cyc;
               exec_lat = (o.tag == TAG_STK) ? 65 : delay_of(o.tag) + 1;
               inflight = 1'b1;
            end
         end
         if (wb_valid && !wb_valid_d && inflight) begin
            check("wb_latency", cyc - exec_cyc, exec_lat);
            inflight = 1'b0;
         end
         wb_valid_d = wb_valid;
         if (hold) begin
            check("hold_valid", wb_valid, 1);
            check("hold_tag", wb_tag, h_tag);
            check("hold_result", wb_result, h_res);
            check("hold_flags", {wb_is_mask, wb_skip, wb_error}, h_flags);
         end
         hold = 1'b0;
         if (wb_valid && wb_ready && rdy_in) begin
            if (exp_q.size() == 0) check("wb_unexpected", 1, 0);
            else begin
               o    = exp_q.pop_front();
               skip = (o.len == 0);
               err  = !skip && (o.tag == TAG_STK);
               check("wb_tag", wb_tag, o.tag);
               check("wb_skip", wb_skip, skip);
               check("wb_error", wb_error, err);
               check("wb_result", wb_result, (skip || err) ? '0 : res_of(o.tag));
               check("wb_is_mask", wb_is_mask, (skip || err) ? 1'b0 : o.tag[0]);
            end
         end else if (wb_valid) begin
            hold    = 1'b1;
            h_tag   = wb_tag;
            h_res   = wb_result;
            h_flags = {wb_is_mask, wb_skip, wb_error};
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_wb) wb_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic push_op(input logic [7:0] t, input logic [31:0] l);
      req_valid  = 1'b1;
      req_tag    = t;
      req_length = l;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (req_ready && rdy_in) begin
            tick();
            req_valid = 1'b0;
            return;
         end
         tick();
      end
      check("push_timeout", 1, 0);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0) begin
            tick();
            return;
         end
         tick();
      end
      check("drain_timeout", 1, 0);
   endtask

   task automatic wait_exec();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (vfu_execute) return;
      end
      check("exec_timeout", 1, 0);
   endtask

   task automatic wait_wb();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (wb_valid) return;
      end
      check("wb_timeout", 1, 0);
   endtask

   task automatic check_reset_outputs(input string t);
      check({t, "_exec"}, vfu_execute, 0);
      check({t, "_vlen"}, vfu_length, 0);
      check({t, "_vtag"}, vfu_tag, 0);
      check({t, "_wbv"}, wb_valid, 0);
      check({t, "_wbtag"}, wb_tag, 0);
      check({t, "_wbres"}, wb_result, 0);
      check({t, "_wbflags"}, {wb_is_mask, wb_skip, wb_error}, 0);
      check({t, "_busy"}, busy, 0);
      check({t, "_rdy"}, req_ready, 1);
   endtask

   initial begin
      logic [7:0]  t;
      logic [31:0] l;
      rst = 1'b1; rdy_in = 1'b1; req_valid = 1'b0; req_tag = '0; req_length = '0; wb_ready = 1'b1;
      tick(); tick();
      check_reset_outputs("rst_init");
      rst = 1'b0;
      tick();

      // Asynchronous reset in the middle of a busy op
      push_op(8'h13, 32'd9);
      wait_exec();
      tick();
      tick();
      #2 rst = 1'b1;
      #1 check_reset_outputs("rst_async");
      tick();
      rst = 1'b0;
      tick();

      // Single op
      push_op(8'h11, 32'd5);
      drain();

      // Queue fill: fifth push stalls until the first pop
      push_op(8'h31, 32'd3);
      push_op(8'h36, 32'd4);
      push_op(8'h3B, 32'd5);
      push_op(8'h40, 32'd6);
      @(negedge clk);
      check("full_stall", req_ready, 0);
      tick();
      push_op(8'h45, 32'd7);
      drain();

      // Zero-length op is skipped
      push_op(8'h22, 32'd0);
      drain();

      // Watchdog abort followed by a normal op
      push_op(TAG_STK, 32'd7);
      push_op(8'h21, 32'd3);
      drain();

      // Writeback backpressure and rdy_in stall during ISSUE
      wb_ready = 1'b0;
      push_op(8'h44, 32'd6);
      tick();
      rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("exec_gated", vfu_execute, 0);
         check("tag_held", vfu_tag, 8'h44);
         tick();
      end
      rdy_in = 1'b1;
      wait_wb();
      for (int i = 0; i < 10; i++) tick();
      wb_ready = 1'b1;
      drain();

      // Random traffic with random writeback backpressure
      rand_wb = 1'b1;
      for (int i = 0; i < 40; i++) begin
         t = 8'($urandom_range(0, 255));
         if (t == TAG_STK) t = 8'hEF;
         l = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
         push_op(t, l);
         repeat ($urandom_range(0, 2)) tick();
      end
      rand_wb  = 1'b0;
      wb_ready = 1'b1;
      drain();

      check("exp_q_empty", exp_q.size(), 0);
      check("iss_q_empty", iss_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
